// File: rtl/pdm2pcm_capture_sequencer_if.sv
// Register-bus and sample-stream bundle between the capture sequencer (master)
// and the pdm2pcm block plus the downstream sample sink (slave side).
interface pdm2pcm_capture_sequencer_if;
  logic        interrupt_i;
  logic        write_o;
  logic [2:0]  write_address_o;
  logic [31:0] write_data_o;
  logic [3:0]  write_strobe_o;
  logic        write_done_i;
  logic        write_error_i;
  logic        read_o;
  logic [2:0]  read_address_o;
  logic [31:0] read_data_i;
  logic        read_done_i;
  logic        read_error_i;
  logic [15:0] sample_o;
  logic        sample_channel_o;
  logic        sample_valid_o;
  logic        sample_ready_i;

  modport master (
    input  interrupt_i, write_done_i, write_error_i, read_data_i, read_done_i,
           read_error_i, sample_ready_i,
    output write_o, write_address_o, write_data_o, write_strobe_o, read_o,
           read_address_o, sample_o, sample_channel_o, sample_valid_o
  );

  modport slave (
    output interrupt_i, write_done_i, write_error_i, read_data_i, read_done_i,
           read_error_i, sample_ready_i,
    input  write_o, write_address_o, write_data_o, write_strobe_o, read_o,
           read_address_o, sample_o, sample_channel_o, sample_valid_o
  );
endinterface

// File: rtl/pdm2pcm_capture_sequencer.sv
// Runs one PDM capture over the pdm2pcm register bus: program gain and control,
// drain PCM samples onto a valid/ready stream on interrupt, then disable.
module pdm2pcm_capture_sequencer #(
  parameter int          LEN_WIDTH   = 16,
  parameter logic [2:0]  CTRL_ADDR   = 3'd0,
  parameter logic [2:0]  GAIN_ADDR   = 3'd1,
  parameter logic [2:0]  BUFFER_ADDR = 3'd3,
  parameter int          ENABLE_BIT  = 31
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [31:0]          cfg_control_i,
  input  logic [15:0]          cfg_gain_i,
  input  logic [LEN_WIDTH-1:0] capture_length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [LEN_WIDTH-1:0] sample_count_o,
  pdm2pcm_capture_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, WR_GAIN, WR_CTRL, WAIT_IRQ, RD_REQ, RD_WAIT, PUSH, WR_DIS, ERROR
  } state_t;

  localparam logic [31:0] EN_MASK = 32'd1 << ENABLE_BIT;

  state_t                 state_q, state_d;
  logic                   wr_sent_q, wr_sent_d;
  logic                   abort_q, abort_d;
  logic [31:0]            ctrl_q;
  logic [15:0]            gain_q;
  logic [LEN_WIDTH-1:0]   len_q, count_q, count_inc;
  logic                   error_q, done_q;
  logic [15:0]            sample_q;
  logic                   chan_q;
  logic [3:0]             strobe_q;
  logic                   load, err_set, bump, capture, done_len0, done_wr;
  logic                   is_wr, wr_req, wr_done, abort_any;
  logic                   unused_rd_bits;

  assign is_wr     = (state_q == WR_GAIN) || (state_q == WR_CTRL) || (state_q == WR_DIS);
  assign wr_req    = is_wr && !wr_sent_q;
  assign wr_done   = is_wr && bus.write_done_i;
  assign abort_any = abort_q || abort_i;
  assign count_inc = count_q + LEN_WIDTH'(1);
  // Only the PCM sample and channel bits of a buffer word carry meaning here.
  assign unused_rd_bits = ^bus.read_data_i[31:17];

  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    load      = 1'b0;
    err_set   = 1'b0;
    bump      = 1'b0;
    capture   = 1'b0;
    done_len0 = 1'b0;
    done_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          abort_d = 1'b0;
          if (capture_length_i == '0) done_len0 = 1'b1;
          else                        state_d   = WR_GAIN;
        end
      end
      WR_GAIN, WR_CTRL: begin
        abort_d = abort_any;
        if (wr_done) begin
          if (bus.write_error_i) begin
            err_set = 1'b1;
            state_d = WR_DIS;
          end else if (abort_any) state_d = WR_DIS;
          else state_d = (state_q == WR_GAIN) ? WR_CTRL : WAIT_IRQ;
        end
      end
      WAIT_IRQ: begin
        if (abort_any) begin
          abort_d = 1'b1;
          state_d = WR_DIS;
        end else if (bus.interrupt_i) state_d = RD_REQ;
      end
      RD_REQ: begin
        abort_d = abort_any;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        abort_d = abort_any;
        // An empty buffer sends us back to wait; a pending abort is honoured there.
        if (bus.read_done_i) begin
          if (bus.read_error_i) state_d = WAIT_IRQ;
          else if (abort_any)   state_d = WR_DIS;
          else begin
            capture = 1'b1;
            state_d = PUSH;
          end
        end
      end
      PUSH: begin
        if (abort_i) begin
          abort_d = 1'b1;
          state_d = WR_DIS;
        end else if (bus.sample_ready_i) begin
          bump    = 1'b1;
          state_d = (count_inc == len_q) ? WR_DIS : WAIT_IRQ;
        end
      end
      WR_DIS: begin
        abort_d = abort_any;
        if (wr_done) begin
          if (bus.write_error_i) begin
            err_set = 1'b1;
            state_d = ERROR;
          end else begin
            done_wr = !(abort_any || error_q);
            state_d = IDLE;
          end
        end
      end
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The request flag re-arms on every state change so each write state pulses once.
    wr_sent_d = (state_d != state_q) ? 1'b0 : (wr_sent_q || wr_req);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      wr_sent_q <= 1'b0;
      abort_q   <= 1'b0;
      ctrl_q    <= '0;
      gain_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      sample_q  <= '0;
      chan_q    <= 1'b0;
      strobe_q  <= 4'h0;
    end else begin
      state_q   <= state_d;
      wr_sent_q <= wr_sent_d;
      abort_q   <= abort_d;
      done_q    <= done_len0;
      strobe_q  <= 4'hF;
      if (load) begin
        ctrl_q  <= cfg_control_i;
        gain_q  <= cfg_gain_i;
        len_q   <= capture_length_i;
        count_q <= '0;
        error_q <= 1'b0;
      end else begin
        if (bump)    count_q <= count_inc;
        if (err_set) error_q <= 1'b1;
      end
      if (capture) begin
        sample_q <= bus.read_data_i[15:0];
        chan_q   <= bus.read_data_i[16];
      end
    end
  end

  always_comb begin
    bus.write_address_o = 3'd0;
    bus.write_data_o    = 32'd0;
    case (state_q)
      WR_GAIN: begin
        bus.write_address_o = GAIN_ADDR;
        bus.write_data_o    = {16'd0, gain_q};
      end
      WR_CTRL: begin
        bus.write_address_o = CTRL_ADDR;
        bus.write_data_o    = ctrl_q | EN_MASK;
      end
      WR_DIS: begin
        bus.write_address_o = CTRL_ADDR;
        bus.write_data_o    = ctrl_q & ~EN_MASK;
      end
      default: ;
    endcase
  end

  assign bus.write_o          = wr_req;
  assign bus.write_strobe_o   = strobe_q;
  assign bus.read_o           = (state_q == RD_REQ);
  assign bus.read_address_o   = bus.read_o ? BUFFER_ADDR : 3'd0;
  assign bus.sample_o         = sample_q;
  assign bus.sample_channel_o = chan_q;
  assign bus.sample_valid_o   = (state_q == PUSH);
  assign busy_o               = (state_q != IDLE);
  assign done_o               = done_q || done_wr;
  assign error_o              = error_q;
  assign sample_count_o       = count_q;

endmodule

// File: tb/tb_pdm2pcm_capture_sequencer.sv
// Self-checking bench: a pdm2pcm bus model and stream sink surround the sequencer;
// each capture is checked against the transactions the register protocol demands.
module tb_pdm2pcm_capture_sequencer;
  localparam logic [31:0] EN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_control = '0;
  logic [15:0] cfg_gain = '0;
  logic [15:0] capture_length = '0;
  logic        busy, done, error;
  logic [15:0] sample_count;

  pdm2pcm_capture_sequencer_if bus();

  pdm2pcm_capture_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
    .cfg_control_i(cfg_control), .cfg_gain_i(cfg_gain), .capture_length_i(capture_length),
    .busy_o(busy), .done_o(done), .error_o(error), .sample_count_o(sample_count),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Bus model configuration, written only by the test tasks.
  int wr_lat = 1;
  int err_wr_idx = -1;
  int err_rd_idx = -1;
  int rdy_mode = 1;
  int irq_mode = 0;

  // Bus model state, written only by the model processes.
  int          wr_count = 0;
  int          rd_count = 0;
  int          wr_wait = 0;
  logic        wr_done_d = 1'b0;
  logic [31:0] rd_word;
  int          idx_now;
  logic [31:0] served_q[$];

  typedef struct packed {
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;
  wr_t         wlog[$];
  logic [16:0] beats_q[$];
  int          done_cnt = 0;
  int          overlap_cnt = 0;
  int          multi_cnt = 0;
  int          rd_addr_bad = 0;
  logic        outst = 1'b0;

  logic [80:0] outs;
  assign outs = {busy, done, error, sample_count, bus.write_o, bus.write_address_o,
                 bus.write_data_o, bus.write_strobe_o, bus.read_o, bus.read_address_o,
                 bus.sample_o, bus.sample_channel_o, bus.sample_valid_o};

  always_comb idx_now = bus.write_o ? wr_count : wr_count - 1;
  assign bus.write_done_i  = (bus.write_o && wr_lat == 0) || wr_done_d;
  assign bus.write_error_i = bus.write_done_i && (idx_now == err_wr_idx);

  always @(posedge clk) begin
    if (bus.write_o) begin
      wr_count  <= wr_count + 1;
      wr_wait   <= (wr_lat > 0) ? wr_lat - 1 : 0;
      wr_done_d <= (wr_lat == 1);
    end else if (wr_wait > 0) begin
      wr_wait   <= wr_wait - 1;
      wr_done_d <= (wr_wait == 1);
    end else begin
      wr_done_d <= 1'b0;
    end
    bus.read_done_i <= bus.read_o;
    if (bus.read_o) begin
      rd_count <= rd_count + 1;
      rd_word = $urandom;
      bus.read_data_i <= rd_word;
      if (rd_count == err_rd_idx) bus.read_error_i <= 1'b1;
      else begin
        bus.read_error_i <= 1'b0;
        served_q.push_back(rd_word);
      end
    end else begin
      bus.read_error_i <= 1'b0;
    end
    case (rdy_mode)
      0:       bus.sample_ready_i <= 1'b0;
      1:       bus.sample_ready_i <= 1'b1;
      default: bus.sample_ready_i <= ($urandom_range(0, 1) == 1);
    endcase
    case (irq_mode)
      0:       bus.interrupt_i <= 1'b0;
      1:       bus.interrupt_i <= 1'b1;
      default: bus.interrupt_i <= ($urandom_range(0, 9) < 7);
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) outst = 1'b0;
    else begin
      if (bus.write_o) wlog.push_back({bus.write_address_o, bus.write_data_o, bus.write_strobe_o});
      if (bus.write_o && bus.read_o) overlap_cnt++;
      if ((bus.write_o || bus.read_o) && outst) multi_cnt++;
      if (bus.read_o && bus.read_address_o !== 3'd3) rd_addr_bad++;
      outst = (outst || bus.write_o || bus.read_o) && !(bus.write_done_i || bus.read_done_i);
      if (bus.sample_valid_o && bus.sample_ready_i) beats_q.push_back({bus.sample_channel_o, bus.sample_o});
      if (done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [15:0] g, input logic [31:0] c, input logic [15:0] l);
    @(negedge clk);
    cfg_gain = g; cfg_control = c; capture_length = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #12;
    total++; if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.write_strobe_o !== 4'hF) begin bad++; $display("FAIL reset_strobe got=%h want=f", bus.write_strobe_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic;
    int w0, b0, s0, d0, r0;
    bit to;
    w0 = wlog.size(); b0 = beats_q.size(); s0 = served_q.size(); d0 = done_cnt; r0 = rd_count;
    wr_lat = 1; rdy_mode = 1; irq_mode = 1;
    pulse_start(16'h0100, 32'h0000_1234, 16'd3);
    wait_idle(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%0d want=0", to); end
    total++; if (wlog.size() - w0 !== 3) begin bad++; $display("FAIL basic_nwrites got=%0d want=3", wlog.size() - w0); end
    total++; if (wlog[w0] !== {3'd1, 32'h0000_0100, 4'hF}) begin bad++; $display("FAIL basic_gain got=%h want=%h", wlog[w0], {3'd1, 32'h100, 4'hF}); end
    total++; if (wlog[w0+1] !== {3'd0, 32'h8000_1234, 4'hF}) begin bad++; $display("FAIL basic_ctrl got=%h want=%h", wlog[w0+1], {3'd0, 32'h8000_1234, 4'hF}); end
    total++; if (wlog[w0+2] !== {3'd0, 32'h0000_1234, 4'hF}) begin bad++; $display("FAIL basic_dis got=%h want=%h", wlog[w0+2], {3'd0, 32'h1234, 4'hF}); end
    total++; if (rd_count - r0 !== 3) begin bad++; $display("FAIL basic_nreads got=%0d want=3", rd_count - r0); end
    total++; if (beats_q.size() - b0 !== 3) begin bad++; $display("FAIL basic_nbeats got=%0d want=3", beats_q.size() - b0); end
    for (int k = 0; k < 3; k++) begin
      total++; if (beats_q[b0+k] !== served_q[s0+k][16:0]) begin bad++; $display("FAIL basic_beat%0d got=%h want=%h", k, beats_q[b0+k], served_q[s0+k][16:0]); end
    end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done got=%0d want=1", done_cnt - d0); end
    total++; if (sample_count !== 16'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", sample_count); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL basic_error got=%b want=0", error); end
  endtask

  task automatic test_random;
    logic [15:0] g, l;
    logic [31:0] c;
    int w0, b0, s0, d0;
    bit to;
    for (int it = 0; it < 4; it++) begin
      g = 16'($urandom); c = $urandom; l = 16'($urandom_range(1, 6));
      wr_lat = $urandom_range(0, 2); rdy_mode = 2; irq_mode = 2;
      w0 = wlog.size(); b0 = beats_q.size(); s0 = served_q.size(); d0 = done_cnt;
      pulse_start(g, c, l);
      wait_idle(to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL rand%0d_timeout got=%0d want=0", it, to); end
      total++; if (wlog.size() - w0 !== 3) begin bad++; $display("FAIL rand%0d_nwrites got=%0d want=3", it, wlog.size() - w0); end
      total++; if (wlog[w0] !== {3'd1, 16'd0, g, 4'hF}) begin bad++; $display("FAIL rand%0d_gain got=%h want=%h", it, wlog[w0], {3'd1, 16'd0, g, 4'hF}); end
      total++; if (wlog[w0+1] !== {3'd0, c | EN, 4'hF}) begin bad++; $display("FAIL rand%0d_ctrl got=%h want=%h", it, wlog[w0+1], {3'd0, c | EN, 4'hF}); end
      total++; if (wlog[w0+2] !== {3'd0, c & ~EN, 4'hF}) begin bad++; $display("FAIL rand%0d_dis got=%h want=%h", it, wlog[w0+2], {3'd0, c & ~EN, 4'hF}); end
      total++; if (beats_q.size() - b0 !== int'(l)) begin bad++; $display("FAIL rand%0d_nbeats got=%0d want=%0d", it, beats_q.size() - b0, l); end
      for (int k = 0; k < int'(l); k++) begin
        total++; if (beats_q[b0+k] !== served_q[s0+k][16:0]) begin bad++; $display("FAIL rand%0d_beat%0d got=%h want=%h", it, k, beats_q[b0+k], served_q[s0+k][16:0]); end
      end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rand%0d_done got=%0d want=1", it, done_cnt - d0); end
      total++; if (sample_count !== l) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", it, sample_count, l); end
    end
  endtask

  task automatic test_read_error;
    int b0, s0, d0, r0;
    bit to;
    b0 = beats_q.size(); s0 = served_q.size(); d0 = done_cnt; r0 = rd_count;
    wr_lat = 1; rdy_mode = 2; irq_mode = 2;
    err_rd_idx = rd_count + 1;
    pulse_start(16'h0042, 32'h0000_0055, 16'd3);
    wait_idle(to);
    err_rd_idx = -1;
    total++; if (to !== 1'b0) begin bad++; $display("FAIL rderr_timeout got=%0d want=0", to); end
    total++; if (rd_count - r0 !== 4) begin bad++; $display("FAIL rderr_nreads got=%0d want=4", rd_count - r0); end
    total++; if (beats_q.size() - b0 !== 3) begin bad++; $display("FAIL rderr_nbeats got=%0d want=3", beats_q.size() - b0); end
    for (int k = 0; k < 3; k++) begin
      total++; if (beats_q[b0+k] !== served_q[s0+k][16:0]) begin bad++; $display("FAIL rderr_beat%0d got=%h want=%h", k, beats_q[b0+k], served_q[s0+k][16:0]); end
    end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rderr_done got=%0d want=1", done_cnt - d0); end
    total++; if (sample_count !== 16'd3) begin bad++; $display("FAIL rderr_count got=%0d want=3", sample_count); end
  endtask

  task automatic test_stall;
    int b0, s0, r0, n;
    logic [15:0] held;
    bit to;
    b0 = beats_q.size(); s0 = served_q.size();
    wr_lat = 2; rdy_mode = 0; irq_mode = 1;
    pulse_start(16'h0007, 32'h0000_00A0, 16'd2);
    n = 0;
    while (!bus.sample_valid_o && n < 200) begin @(negedge clk); n++; end
    total++; if (bus.sample_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", bus.sample_valid_o); end
    held = bus.sample_o; r0 = rd_count;
    total++; if (held !== served_q[s0][15:0]) begin bad++; $display("FAIL stall_first got=%h want=%h", held, served_q[s0][15:0]); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if ({bus.sample_valid_o, bus.sample_o, bus.read_o} !== {1'b1, held, 1'b0}) begin
        bad++; $display("FAIL stall_cyc%0d got=%b/%h/%b want=1/%h/0", k, bus.sample_valid_o, bus.sample_o, bus.read_o, held);
      end
    end
    total++; if (rd_count - r0 !== 0) begin bad++; $display("FAIL stall_reads got=%0d want=0", rd_count - r0); end
    rdy_mode = 1;
    wait_idle(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL stall_timeout got=%0d want=0", to); end
    total++; if (beats_q.size() - b0 !== 2) begin bad++; $display("FAIL stall_nbeats got=%0d want=2", beats_q.size() - b0); end
  endtask

  task automatic test_write_error;
    int w0, d0, r0;
    bit to;
    w0 = wlog.size(); d0 = done_cnt; r0 = rd_count;
    wr_lat = 0; rdy_mode = 1; irq_mode = 1;
    err_wr_idx = wr_count + 1;
    pulse_start(16'h0011, 32'h0000_0F0F, 16'd4);
    wait_idle(to);
    err_wr_idx = -1;
    total++; if (to !== 1'b0) begin bad++; $display("FAIL wrerr_timeout got=%0d want=0", to); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL wrerr_error got=%b want=1", error); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrerr_busy got=%b want=0", busy); end
    total++; if (wlog.size() - w0 !== 3) begin bad++; $display("FAIL wrerr_nwrites got=%0d want=3", wlog.size() - w0); end
    total++; if (wlog[w0+2] !== {3'd0, 32'h0000_0F0F, 4'hF}) begin bad++; $display("FAIL wrerr_dis got=%h want=%h", wlog[w0+2], {3'd0, 32'h0F0F, 4'hF}); end
    total++; if (rd_count - r0 !== 0) begin bad++; $display("FAIL wrerr_reads got=%0d want=0", rd_count - r0); end
    repeat (5) @(negedge clk);
    total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL wrerr_done got=%0d want=0", done_cnt - d0); end
  endtask

  task automatic test_abort;
    int w0, b0, d0, r0, n;
    bit to;
    w0 = wlog.size(); b0 = beats_q.size(); d0 = done_cnt; r0 = rd_count;
    wr_lat = 2; rdy_mode = 1; irq_mode = 1;
    pulse_start(16'h0033, 32'h0000_0C0C, 16'd3);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL abort_errclr got=%b want=0", error); end
    n = 0;
    while (sample_count !== 16'd1 && n < 300) begin @(negedge clk); n++; end
    rdy_mode = 0;
    n = 0;
    while (!bus.sample_valid_o && n < 300) begin @(negedge clk); n++; end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_idle(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL abort_timeout got=%0d want=0", to); end
    total++; if (beats_q.size() - b0 !== 1) begin bad++; $display("FAIL abort_nbeats got=%0d want=1", beats_q.size() - b0); end
    total++; if (sample_count !== 16'd1) begin bad++; $display("FAIL abort_count got=%0d want=1", sample_count); end
    total++; if (wlog.size() - w0 !== 3) begin bad++; $display("FAIL abort_nwrites got=%0d want=3", wlog.size() - w0); end
    total++; if (wlog[w0+2] !== {3'd0, 32'h0000_0C0C, 4'hF}) begin bad++; $display("FAIL abort_dis got=%h want=%h", wlog[w0+2], {3'd0, 32'h0C0C, 4'hF}); end
    total++; if (rd_count - r0 !== 2) begin bad++; $display("FAIL abort_nreads got=%0d want=2", rd_count - r0); end
    repeat (3) @(negedge clk);
    total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt - d0); end
    // abort alone in idle does nothing; start with abort in idle starts a normal capture
    rdy_mode = 1; w0 = wlog.size();
    abort = 1'b1; @(negedge clk); abort = 1'b0; @(negedge clk);
    total++; if ({busy, 1'b0} !== {1'b0, 1'b0} || wlog.size() !== w0) begin bad++; $display("FAIL abort_idle got=%b/%0d want=0/%0d", busy, wlog.size(), w0); end
    d0 = done_cnt;
    cfg_gain = 16'h0001; cfg_control = 32'h0000_0001; capture_length = 16'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_abort_busy got=%b want=1", busy); end
    wait_idle(to);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL start_abort_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_len0_reset;
    int w0, r0, n;
    w0 = wlog.size(); r0 = rd_count;
    rdy_mode = 1; irq_mode = 1; wr_lat = 1;
    pulse_start(16'h0055, 32'h0000_0077, 16'd0);
    total++; if ({done, busy} !== 2'b10) begin bad++; $display("FAIL len0_done got=%b%b want=10", done, busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL len0_pulse got=%b want=0", done); end
    repeat (5) @(negedge clk);
    total++; if (wlog.size() - w0 !== 0 || rd_count - r0 !== 0) begin bad++; $display("FAIL len0_traffic got=%0d/%0d want=0/0", wlog.size() - w0, rd_count - r0); end
    rdy_mode = 0;
    pulse_start(16'h0002, 32'h0000_0003, 16'd4);
    n = 0;
    while (!bus.read_o && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (outs !== '0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", outs); end
    rdy_mode = 1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if ({busy, bus.write_strobe_o} !== {1'b0, 4'hF}) begin bad++; $display("FAIL midreset_after got=%b/%h want=0/f", busy, bus.write_strobe_o); end
  endtask

  task automatic test_bus_rules;
    total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL bus_overlap got=%0d want=0", overlap_cnt); end
    total++; if (multi_cnt !== 0) begin bad++; $display("FAIL bus_outstanding got=%0d want=0", multi_cnt); end
    total++; if (rd_addr_bad !== 0) begin bad++; $display("FAIL bus_rdaddr got=%0d want=0", rd_addr_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_read_error();
    test_stall();
    test_write_error();
    test_abort();
    test_len0_reset();
    test_bus_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
